// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_pkg
// Description : Shared Keccak-f[1600] constants and the arbiter FSM state
//               encoding, imported by the arbiter RTL and its benches.
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int LANE_W  = 64;
    localparam int LANES   = 25;
    localparam int STATE_W = 1600;

    // Arbiter FSM encoding; kept here so benches can name states directly.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_t;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational next-grant selection for keccak_arbiter.
//               Searches req upward from rr_ptr with wrap-around and also
//               computes the pointer value to store once a grant retires.
//               Build option KECCAK_ARB_FIXED_PRIO_EN: requester 0 always
//               wins; requesters 1..N_REQ-1 rotate among themselves and the
//               pointer never selects 0.
// Ports       : i_req       - request vector
//               i_rr_ptr    - current round-robin pointer
//               i_cur       - grant being retired (for next pointer)
//               o_valid     - at least one request is pending
//               o_grant     - selected requester index
//               o_next_ptr  - pointer to store when i_cur retires
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int GW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [GW-1:0]    i_rr_ptr,
    input  logic [GW-1:0]    i_cur,
    output logic             o_valid,
    output logic [GW-1:0]    o_grant,
    output logic [GW-1:0]    o_next_ptr
);

    // Walk candidates from farthest to nearest so the nearest set bit is
    // the last assignment and wins without needing a loop break.
    always_comb begin
        int          w_idx;
        int          w_start;
        logic [GW-1:0] w_sel;
        w_idx   = 0;
        w_start = 0;
        w_sel   = '0;
        o_valid = 1'b0;
        o_grant = '0;
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        // A reset pointer of 0 behaves as 1 in the rotating subset.
        w_start = (i_rr_ptr == '0) ? 1 : int'(i_rr_ptr);
        for (int k = N_REQ - 2; k >= 0; k--) begin
            w_idx = 1 + ((w_start - 1 + k) % (N_REQ - 1));
            w_sel = GW'(w_idx);
            if (i_req[w_sel]) begin
                o_valid = 1'b1;
                o_grant = w_sel;
            end
        end
        if (i_req[0]) begin
            o_valid = 1'b1;
            o_grant = '0;
        end
`else
        w_start = int'(i_rr_ptr);
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (w_start + k) % N_REQ;
            w_sel = GW'(w_idx);
            if (i_req[w_sel]) begin
                o_valid = 1'b1;
                o_grant = w_sel;
            end
        end
`endif
    end

    always_comb begin
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        // Serving requester 0 leaves the rotation among the others intact.
        if (i_cur == '0) begin
            o_next_ptr = i_rr_ptr;
        end else if (i_cur == GW'(N_REQ - 1)) begin
            o_next_ptr = GW'(1);
        end else begin
            o_next_ptr = i_cur + GW'(1);
        end
`else
        if (i_cur == GW'(N_REQ - 1)) begin
            o_next_ptr = '0;
        end else begin
            o_next_ptr = i_cur + GW'(1);
        end
`endif
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/keccak_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : keccak_arbiter
// Description : Shares one Keccak-f[1600] permutation core among N_REQ
//               sponge users. Grants one requester at a time, forwards its
//               state to the core over a four-phase rtr/rts handshake,
//               captures the permuted state and signals done to the owner.
//               Build option KECCAK_ARB_FIXED_PRIO_EN gives requester 0
//               absolute priority (see rr_arbiter).
// Ports       : clock, reset      - clock, synchronous active-high reset
//               req/linear_s_req  - request levels and flattened states
//               done/linear_s_out - per-requester done level, result state
//               grant_id          - current owner index
//               perm_rtr/perm_s_in   - start request and state to the core
//               perm_rts/perm_s_out  - core result valid and state
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_arbiter
    import keccak_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int GW    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*STATE_W-1:0] linear_s_req,
    output logic [N_REQ-1:0]         done,
    output logic [STATE_W-1:0]       linear_s_out,
    output logic [GW-1:0]            grant_id,
    output logic                     perm_rtr,
    output logic [STATE_W-1:0]       perm_s_in,
    input  logic                     perm_rts,
    input  logic [STATE_W-1:0]       perm_s_out
);

    arb_state_t           r_state;
    logic [GW-1:0]        r_rr_ptr;
    logic                 w_valid;
    logic [GW-1:0]        w_grant;
    logic [GW-1:0]        w_next_ptr;
    logic [STATE_W-1:0]   w_slice;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_rr_arbiter (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .i_cur      (grant_id),
        .o_valid    (w_valid),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    // State slice of the current owner.
    always_comb begin
        w_slice = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                w_slice = linear_s_req[i*STATE_W +: STATE_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            grant_id     <= '0;
            perm_rtr     <= 1'b0;
            done         <= '0;
            linear_s_out <= '0;
            perm_s_in    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        grant_id <= w_grant;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    perm_s_in <= w_slice;
                    perm_rtr  <= 1'b1;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (perm_rts) begin
                        linear_s_out <= perm_s_out;
                        perm_rtr     <= 1'b0;
                        r_state      <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Core must finish its own handshake before reuse.
                    if (!perm_rts) begin
                        done    <= N_REQ'(1) << grant_id;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // An owner that already dropped req sees a one-cycle pulse.
                    if (!req[grant_id]) begin
                        done     <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : keccak_arbiter
`default_nettype wire

// File: tb/tb_keccak_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_arbiter
// Description : Self-checking bench for keccak_arbiter: directed scenarios
//               plus randomized requesters and core timing, checked every
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_arbiter;
    import keccak_pkg::*;

    localparam int N  = 3;
    localparam int GW = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req = '0;
    logic [N*STATE_W-1:0] linear_s_req = '0;
    logic [N-1:0]         done;
    logic [STATE_W-1:0]   linear_s_out;
    logic [GW-1:0]        grant_id;
    logic                 perm_rtr;
    logic [STATE_W-1:0]   perm_s_in;
    logic                 perm_rts;
    logic [STATE_W-1:0]   perm_s_out;

    int checks   = 0;
    int failures = 0;

    keccak_arbiter #(.N_REQ(N), .GW(GW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .linear_s_req (linear_s_req),
        .done         (done),
        .linear_s_out (linear_s_out),
        .grant_id     (grant_id),
        .perm_rtr     (perm_rtr),
        .perm_s_in    (perm_s_in),
        .perm_rts     (perm_rts),
        .perm_s_out   (perm_s_out)
    );

    always #5 clock = ~clock;

    function automatic logic [STATE_W-1:0] mask_st(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] r;
        r = s;
        for (int l = 0; l < LANES; l++) r[l*LANE_W +: LANE_W] = r[l*LANE_W +: LANE_W] ^ 64'hFF;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_st(input string nm, input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] exp);
        int ln;
        checks++;
        if (act !== exp) begin
            failures++;
            ln = 0;
            for (int l = LANES - 1; l >= 0; l--)
                if (act[l*LANE_W +: LANE_W] !== exp[l*LANE_W +: LANE_W]) ln = l;
            $display("FAIL %s lane=%0d actual=%0h required=%0h t=%0t", nm, ln,
                     act[ln*LANE_W +: LANE_W], exp[ln*LANE_W +: LANE_W], $time);
        end
    endtask

    // ---------------- core model ----------------
    int core_lat  = 2;
    int core_hold = 0;
    int c_cnt, c_hold;
    always @(posedge clock) begin
        if (reset) begin
            perm_rts   <= 1'b0;
            perm_s_out <= '0;
            c_cnt      <= 0;
            c_hold     <= 0;
        end else if (perm_rtr && !perm_rts) begin
            if (c_cnt >= core_lat) begin
                perm_rts   <= 1'b1;
                perm_s_out <= mask_st(perm_s_in);
                c_cnt      <= 0;
            end else begin
                c_cnt <= c_cnt + 1;
            end
        end else if (!perm_rtr && perm_rts) begin
            if (c_hold >= core_hold) begin
                perm_rts <= 1'b0;
                c_hold   <= 0;
            end else begin
                c_hold <= c_hold + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_arb(input logic [N-1:0] r, input int ptr);
        int order[$];
        logic [N-1:0] sh;
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        if (r[0]) return 0;
        for (int k = 0; k < N - 1; k++) order.push_back(1 + (((ptr == 0) ? 0 : ptr - 1) + k) % (N - 1));
`else
        for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
`endif
        foreach (order[j]) begin
            sh = r >> order[j];
            if (sh[0]) return order[j];
        end
        return -1;
    endfunction

    function automatic int model_next(input int g, input int ptr);
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        if (g == 0) return ptr;
        return (g == N - 1) ? 1 : g + 1;
`else
        return (g + 1) % N;
`endif
    endfunction

    int  cyc = 0;
    bit  m_busy = 0, m_seen_done = 0, m_rst_chk = 0;
    int  m_g = 0, m_ptr = 0, m_t0 = 0, age;
    logic [STATE_W-1:0] m_exp;
    int  glog[$];

    always @(negedge clock) begin
        cyc++;
        if (m_rst_chk) begin
            chk("reset_rtr", 64'(perm_rtr), 0);
            chk("reset_done", 64'(done), 0);
            chk("reset_grant", 64'(grant_id), 0);
            chk("reset_state", 64'(dut.r_state == ST_IDLE), 1);
            chk_st("reset_sout", linear_s_out, '0);
            chk_st("reset_sin", perm_s_in, '0);
            m_rst_chk = 0;
        end
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_rst_chk = 1;
        end else begin
            if (perm_rts) chk("done_while_rts", 64'(done), 0);
            if (m_busy) begin
                age = cyc - m_t0;
                if (age == 1) begin
                    chk("grant_id", 64'(grant_id), 64'(m_g));
                    chk("rtr_at_t1", 64'(perm_rtr), 0);
                    glog.push_back(int'(grant_id));
                    m_exp = linear_s_req[m_g*STATE_W +: STATE_W];
                end
                if (age == 2) begin
                    chk("rtr_at_t2", 64'(perm_rtr), 1);
                    chk_st("perm_s_in", perm_s_in, m_exp);
                end
                if (age > 400) begin
                    chk("grant_stall", 64'(age), 0);
                    m_busy = 0;
                end
                if (done != '0) begin
                    chk("done_onehot", 64'(done), 64'(1) << m_g);
                    chk("rtr_in_done", 64'(perm_rtr), 0);
                    if (!m_seen_done) chk_st("linear_s_out", linear_s_out, mask_st(m_exp));
                    m_seen_done = 1;
                    if (!req[m_g]) begin
                        m_busy = 0;
                        m_ptr  = model_next(m_g, m_ptr);
                    end
                end else if (m_seen_done) begin
                    chk("done_dropped_early", 64'(done), 64'(1) << m_g);
                end
            end else begin
                chk("idle_done", 64'(done), 0);
                chk("idle_rtr", 64'(perm_rtr), 0);
                if (req != '0) begin
                    m_g = model_arb(req, m_ptr);
                    m_busy = 1; m_seen_done = 0; m_t0 = cyc;
                end
            end
        end
    end

    // ---------------- requester agents ----------------
    bit agents_on = 0, raise_en = 0;
    int fixed_gap = 1;
    int low_cnt[N];

    task automatic set_state(input int i);
        for (int w = 0; w < STATE_W / 32; w++) linear_s_req[i*STATE_W + w*32 +: 32] = $urandom;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (agents_on) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && done[i]) begin
                    req[i] = 1'b0;
                    low_cnt[i] = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 4));
                end else if (!req[i] && raise_en) begin
                    if (low_cnt[i] > 0) low_cnt[i]--;
                    else begin set_state(i); req[i] = 1'b1; end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    int cnt, dcnt, rts_hi;
    int exp_seq[5];
    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        @(negedge clock);
        chk("init_grant", 64'(grant_id), 0);
        chk("init_done", 64'(done), 0);

        // Single request: lane0 = 1, latency 24.
        core_lat = 23;
        linear_s_req = '0;
        linear_s_req[STATE_W +: 64] = 64'h1;
        req = 3'b010;
        cnt = 0;
        while (done == '0 && cnt < 200) begin step(); cnt++; end
        chk("single_timeout", 64'(cnt < 200), 1);
        @(negedge clock);
        chk("single_grant", 64'(grant_id), 1);
        chk("single_lane0", linear_s_out[63:0], 64'hFE);
        chk("single_done", 64'(done), 64'b010);
        repeat (3) step();
        @(negedge clock);
        chk("single_done_held", 64'(done), 64'b010);
        req = '0;
        repeat (3) step();

        // Round-robin / fixed-priority sequence from pointer 0.
        do_reset();
        core_lat = 2;
        glog.delete();
        for (int i = 0; i < N; i++) begin set_state(i); low_cnt[i] = 0; end
        fixed_gap = 1;
        req = 3'b111;
        agents_on = 1; raise_en = 1;
        cnt = 0;
        while (glog.size() < 5 && cnt < 500) begin step(); cnt++; end
        chk("rr_timeout", 64'(cnt < 500), 1);
        raise_en = 0;
        cnt = 0;
        while ((req != '0 || m_busy) && cnt < 500) begin step(); cnt++; end
        agents_on = 0;
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 1, 0, 2, 0};
`else
        exp_seq = '{0, 1, 2, 0, 1};
`endif
        for (int j = 0; j < 5; j++) chk($sformatf("grant_seq%0d", j), 64'(glog[j]), 64'(exp_seq[j]));

        // Reset while perm_rtr is high.
        req = 3'b010;
        cnt = 0;
        while (!perm_rtr && cnt < 50) begin step(); cnt++; end
        chk("midrun_timeout", 64'(cnt < 50), 1);
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("midrun_rtr", 64'(perm_rtr), 0);
        chk("midrun_done", 64'(done), 0);
        chk("midrun_grant", 64'(grant_id), 0);
        chk("midrun_state", 64'(dut.r_state == ST_IDLE), 1);
        repeat (2) step();

        // Early drop of req[2] during RUN.
        do_reset();
        core_lat = 3;
        req = 3'b100;
        cnt = 0;
        while (!perm_rtr && cnt < 50) begin step(); cnt++; end
        req = '0;
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done[2]) dcnt++;
        end
        chk("early_done_cycles", 64'(dcnt), 1);
        @(negedge clock);
        chk("early_state", 64'(dut.r_state == ST_IDLE), 1);
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        chk("early_rr_ptr", 64'(dut.r_rr_ptr), 1);
`else
        chk("early_rr_ptr", 64'(dut.r_rr_ptr), 0);
`endif

        // Slow core release: perm_rts held 5 cycles after perm_rtr falls.
        core_hold = 4;
        set_state(0);
        req = 3'b001;
        cnt = 0;
        while (!perm_rtr && cnt < 50) begin step(); cnt++; end
        while (perm_rtr && cnt < 100) begin step(); cnt++; end
        rts_hi = 0;
        while (done == '0 && cnt < 100) begin
            if (perm_rts) rts_hi++;
            step(); cnt++;
        end
        chk("slow_rts_cycles", 64'(rts_hi), 5);
        chk("slow_done", 64'(done), 64'b001);
        req = '0;
        core_hold = 0;
        repeat (3) step();

        // Randomized traffic and core timing.
        do_reset();
        fixed_gap = -1;
        for (int i = 0; i < N; i++) low_cnt[i] = int'($urandom_range(0, 3));
        agents_on = 1; raise_en = 1;
        for (int k = 0; k < 3000; k++) begin
            if (!perm_rtr && !perm_rts) begin
                core_lat  = int'($urandom_range(0, 6));
                core_hold = int'($urandom_range(0, 3));
            end
            step();
        end
        raise_en = 0;
        cnt = 0;
        while ((req != '0 || m_busy) && cnt < 500) begin step(); cnt++; end
        chk("drain_timeout", 64'(cnt < 500), 1);
        agents_on = 0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule : tb_keccak_arbiter
`default_nettype wire
